// File: rtl/vga_pkg.sv
// Shared scanout timing, framebuffer geometry and sink FSM state.
// Address helper maps (x, y) to y*320 + x using shifts only.
package vga_pkg;

    localparam int COLOR_W  = 12;
    localparam int FB_DEPTH = 76800;

    localparam logic [8:0]  H_RES   = 9'd320;
    localparam logic [7:0]  V_RES   = 8'd240;
    localparam logic [16:0] FB_LAST = 17'd76799;

    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_BP   = 10'd48;
    localparam logic [9:0] H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_SS   = H_VIS + H_FP;
    localparam logic [9:0] H_SE   = H_SS + H_SYNC;
    localparam logic [9:0] H_MAX  = H_TOT - 10'd1;

    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_BP   = 10'd33;
    localparam logic [9:0] V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_SS   = V_VIS + V_FP;
    localparam logic [9:0] V_SE   = V_SS + V_SYNC;
    localparam logic [9:0] V_MAX  = V_TOT - 10'd1;

    typedef enum logic {CLEAR, RUN} state_t;

    function automatic logic [16:0] pix_addr(
        input logic [8:0] x,
        input logic [7:0] y
    );
        logic [16:0] yy;
        yy = {9'd0, y};
        return (yy << 8) + (yy << 6) + {8'd0, x};
    endfunction

endpackage

// File: rtl/pixel_sink_scanout_if.sv
// Pixel-write stream from the view logic into the framebuffer sink.
// No backpressure: ready only says the clear sweep has finished.
interface pixel_sink_scanout_if;
    import vga_pkg::*;

    logic [8:0]         X_in;
    logic [7:0]         Y_in;
    logic [COLOR_W-1:0] Color_in;
    logic               writeEn;
    logic               ready;

    modport master (
        output X_in, Y_in, Color_in, writeEn,
        input  ready
    );

    modport slave (
        input  X_in, Y_in, Color_in, writeEn,
        output ready
    );

endinterface

// File: rtl/fb_ram.sv
// 76800x12 simple dual-port framebuffer, registered read.
// Read-during-write to the same address returns the old word.
module fb_ram
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [16:0]        waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [16:0]        raddr,
    output logic [COLOR_W-1:0] rdata
);

    logic [COLOR_W-1:0] mem [FB_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pixel_sink_scanout.sv
// 320x240 framebuffer sink with 2x-scaled 640x480@60 VGA scanout.
// Define PIXEL_DROP_COUNT_EN to count out-of-range writes on drop_count.
module pixel_sink_scanout
    import vga_pkg::*;
#(
    parameter logic [COLOR_W-1:0] BG_COLOR = 12'h000
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_sink_scanout_if.slave  px,
    output logic [15:0]          drop_count,
    output logic [7:0]           VGA_R,
    output logic [7:0]           VGA_G,
    output logic [7:0]           VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK_N,
    output logic                 VGA_SYNC_N,
    output logic                 VGA_CLK
);

    state_t             state, state_nx;
    logic [16:0]        clr_addr, clr_nx;
    logic               we;
    logic [16:0]        waddr;
    logic [COLOR_W-1:0] wdata;
    logic               in_range;

    assign in_range = (px.X_in < H_RES) && (px.Y_in < V_RES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clr_nx   = clr_addr;
        we       = 1'b0;
        waddr    = clr_addr;
        wdata    = BG_COLOR;
        unique case (state)
            CLEAR: begin
                we = 1'b1;
                if (clr_addr == FB_LAST) state_nx = RUN;
                else clr_nx = clr_addr + 17'd1;
            end
            RUN: begin
                we    = px.writeEn && in_range;
                waddr = pix_addr(px.X_in, px.Y_in);
                wdata = px.Color_in;
            end
        endcase
    end

    assign px.ready = (state == RUN);

`ifdef PIXEL_DROP_COUNT_EN
    logic [15:0] drops;

    always_ff @(posedge clk) begin
        if (reset) begin
            drops <= '0;
        end else if (state == RUN && px.writeEn && !in_range
                     && drops != 16'hFFFF) begin
            drops <= drops + 16'd1;
        end
    end

    assign drop_count = drops;
`else
    assign drop_count = '0;
`endif

    logic        pix_en;
    logic [9:0]  hcnt, vcnt;
    logic        vis, hs, vs;
    logic [16:0] raddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en <= 1'b0;
            hcnt   <= '0;
            vcnt   <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (hcnt == H_MAX) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_MAX) ? '0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    assign vis   = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign hs    = !((hcnt >= H_SS) && (hcnt < H_SE));
    assign vs    = !((vcnt >= V_SS) && (vcnt < V_SE));
    // Blanked region reads address 0 so the index never leaves the array.
    assign raddr = vis ? pix_addr(hcnt[9:1], vcnt[8:1]) : '0;

    logic [COLOR_W-1:0] rdata;

    fb_ram u_fb (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    logic vis_q, hs_q, vs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vis_q       <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            vis_q       <= vis;
            hs_q        <= hs;
            vs_q        <= vs;
            VGA_HS      <= hs_q;
            VGA_VS      <= vs_q;
            VGA_BLANK_N <= vis_q;
            VGA_R       <= vis_q ? {rdata[11:8], rdata[11:8]} : '0;
            VGA_G       <= vis_q ? {rdata[7:4], rdata[7:4]} : '0;
            VGA_B       <= vis_q ? {rdata[3:0], rdata[3:0]} : '0;
        end
    end

    assign VGA_SYNC_N = 1'b0;
    assign VGA_CLK    = pix_en;

endmodule

// File: tb/tb_pixel_sink_scanout.sv
// Random-write bench for pixel_sink_scanout against a frame-level model.
// Expected scanout comes from clock count since reset and a model framebuffer.
module tb_pixel_sink_scanout;
    import vga_pkg::*;

    localparam int NPIX = 76800;
    localparam logic [26:0] RST_V = {3'b110, 24'h0};
    localparam logic [26:0] ALL_M = 27'h7FFFFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    pixel_sink_scanout_if px();

    logic [15:0] drop_count;
    logic [7:0]  r, g, b;
    logic        hs, vs, bl, sn, vclk;

    pixel_sink_scanout dut (
        .clk         (clk),
        .reset       (reset),
        .px          (px),
        .drop_count  (drop_count),
        .VGA_R       (r),
        .VGA_G       (g),
        .VGA_B       (b),
        .VGA_HS      (hs),
        .VGA_VS      (vs),
        .VGA_BLANK_N (bl),
        .VGA_SYNC_N  (sn),
        .VGA_CLK     (vclk)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: frame contents, which words are known, clocks since reset.
    logic [11:0] fb [NPIX];
    bit          known [NPIX];
    int          ncyc = 0;
    bit          rst_q = 1'b0;
    int          drops_exp = 0;

    function automatic int idx(input int x, input int y);
        return y * 320 + x;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ncyc  <= 0;
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            ncyc  <= ncyc + 1;
            if (ncyc < NPIX) begin
                fb[ncyc]    <= 12'h000;
                known[ncyc] <= 1'b1;
            end else if (px.writeEn) begin
                if (px.X_in < 320 && px.Y_in < 240) begin
                    fb[idx(int'(px.X_in), int'(px.Y_in))]    <= px.Color_in;
                    known[idx(int'(px.X_in), int'(px.Y_in))] <= 1'b1;
                end else begin
                    drops_exp <= drops_exp + 1;
                end
            end
        end
    end

    // Screen state implied by k clocks since reset, before pipeline delay.
    task automatic expect_at(input int k, output logic [26:0] v,
                             output logic [26:0] m);
        int p, h, y, a;
        bit vis;
        logic [11:0] c;
        p   = k / 2;
        h   = p % 800;
        y   = (p / 800) % 525;
        vis = (h < 640) && (y < 480);
        c   = 12'h000;
        m   = ALL_M;
        if (vis) begin
            a = (y / 2) * 320 + h / 2;
            if (known[a]) c = fb[a];
            else m = {3'b111, 24'h0};
        end
        v = {!(h >= 656 && h < 752), !(y >= 490 && y < 492), vis,
             c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    endtask

    logic [26:0] qv[$];
    logic [26:0] qm[$];
    bit mon_on = 1'b0;

    always @(negedge clk) begin
        logic [26:0] v, m, ev, em;
        if (rst_q) begin
            expect_at(0, v, m);
            qv = {RST_V, v};
            qm = {ALL_M, m};
            ev = RST_V;
            em = ALL_M;
        end else begin
            expect_at(ncyc, v, m);
            qv.push_back(v);
            qm.push_back(m);
            ev = qv.pop_front();
            em = qm.pop_front();
        end
        if (mon_on)
            chk("scan", {5'd0, {hs, vs, bl, r, g, b} & em}, {5'd0, ev & em});
    end

    task automatic put_on(input logic [8:0] x, input logic [7:0] y,
                          input logic [11:0] c);
        px.X_in     = x;
        px.Y_in     = y;
        px.Color_in = c;
        px.writeEn  = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        px.writeEn = 1'b0;
    endtask

    task automatic at_neg(input int n);
        @(negedge clk);
        while (ncyc < n) @(negedge clk);
    endtask

    initial begin
        int  cnt, hsl, bll, vsl;
        bit  done;
        px.writeEn  = 1'b0;
        px.X_in     = '0;
        px.Y_in     = '0;
        px.Color_in = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        chk("rst_ready", {31'd0, px.ready}, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);
        chk("rst_vga", {5'd0, hs, vs, bl, r, g, b}, {5'd0, RST_V});
        chk("sync_n", {31'd0, sn}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Line 0 timing and writes ignored during the sweep.
        hsl = 0;
        bll = 0;
        vsl = 0;
        while (ncyc < 1700) begin
            step;
            if (ncyc == 1000) put_on(9'd3, 8'd0, 12'hFFF);
            if (ncyc == 1001) put_on(9'd400, 8'd0, 12'hABC);
            @(negedge clk);
            if (ncyc >= 2 && ncyc <= 1601) begin
                hsl += int'(!hs);
                bll += int'(bl);
                vsl += int'(!vs);
            end
            if (ncyc == 1614) chk("clr_ignored", {8'd0, r, g, b}, 32'd0);
        end
        chk("hs_low", 32'(hsl), 32'd192);
        chk("blank_hi", 32'(bll), 32'd1280);
        chk("vs_low", 32'(vsl), 32'd0);
        chk("clr_ready", {31'd0, px.ready}, 32'd0);
        chk("clr_drop", {16'd0, drop_count}, 32'd0);

        // Reset in mid-sweep, then time the full restart.
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, px.ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 80000) begin
            step;
            cnt++;
            if (cnt >= 70000 && cnt < 70008)
                put_on(9'((cnt - 70000) * 3), 8'd25, 12'hF0F);
            if (cnt == 70010) put_on(9'd330, 8'd25, 12'h0FF);
            if (px.ready) done = 1'b1;
        end
        chk("ready_clks", 32'(cnt), 32'd76800);

        put_on(9'd5, 8'd25, 12'hF00);
        step;
        put_on(9'd320, 8'd0, 12'h123);
        step;
        put_on(9'd0, 8'd240, 12'h456);
        step;
        put_on(9'd320, 8'd25, 12'h00F);
        step;
        for (int i = 0; i < 12; i++) begin
            put_on(9'($urandom_range(0, 319)), 8'd27, 12'($urandom));
            step;
        end
        for (int i = 0; i < 8; i++) begin
            put_on(9'($urandom_range(0, 319)), 8'($urandom_range(28, 239)),
                   12'($urandom));
            step;
        end
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                put_on(9'($urandom_range(320, 511)), 8'($urandom_range(0, 255)),
                       12'($urandom));
            else
                put_on(9'($urandom_range(0, 319)), 8'($urandom_range(240, 255)),
                       12'($urandom));
            step;
        end

        // 2x2 block of (5,25) sits on hcnt 10-11, vcnt 50-51.
        at_neg(78422);
        chk("row24_bg", {8'd0, r, g, b}, 32'd0);
        at_neg(80021);
        chk("blk_left", {8'd0, r, g, b}, 32'd0);
        at_neg(80022);
        chk("blk_v50_h10", {8'd0, r, g, b}, 32'h00FF0000);
        at_neg(80025);
        chk("blk_v50_h11", {8'd0, r, g, b}, 32'h00FF0000);
        at_neg(80026);
        chk("clr_write_gone", {8'd0, r, g, b}, 32'd0);
        at_neg(81622);
        chk("blk_v51_h10", {8'd0, r, g, b}, 32'h00FF0000);
        at_neg(81625);
        chk("blk_v51_h11", {8'd0, r, g, b}, 32'h00FF0000);

        // Write the word being read this very clock.
        while (ncyc < 83600) begin
            @(posedge clk);
            #1;
        end
        put_on(9'd100, 8'd26, 12'h0F0);
        step;
        at_neg(83602);
        chk("raw_old", {24'd0, g}, 32'd0);
        at_neg(83603);
        chk("raw_new", {24'd0, g}, 32'h000000FF);

        at_neg(88000);
`ifdef PIXEL_DROP_COUNT_EN
        chk("drop_count", {16'd0, drop_count},
            32'((drops_exp > 65535) ? 65535 : drops_exp));
`else
        chk("drop_count", {16'd0, drop_count}, 32'd0);
        if (drops_exp < 0) $display("drops %0d", drops_exp);
`endif
        chk("ready_hold", {31'd0, px.ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
